pipelined_lane_adder: RTL and testbench
=======================================

Name: pipelined_lane_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 32-bit split-lane adder.
- Operands are split into LANES lanes of LANE_W bits. Each pipeline stage adds one lane, LSB lane first.
- A per-transaction mode selects packed-SIMD addition (independent lanes, carries dropped between lanes) or full-width addition (carry rippled stage to stage).
- Sits between operand producers and consumers on a valid/ready stream with full backpressure.

Parameters:
- WIDTH, 32, total operand/sum width in bits
- LANE_W, 8, lane width in bits; WIDTH must be an integer multiple of LANE_W (elaboration error otherwise)
- LANES, WIDTH/LANE_W, derived, not overridable; also equals pipeline depth and latency

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_mode  input  1  0 = packed independent lanes, 1 = full-width carry chain
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  sum
- out_carry  output  LANES  carry-out of each lane; bit i belongs to lane i; in mode 1, bit LANES-1 is the full-width carry-out

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits cleared, out_valid=0, out_sum=0, out_carry=0.
  - in_ready=1 on the first cycle after release.
  - Reset mid-operation discards every in-flight beat; none emerge after release.
- Pipeline: LANES register stages; stage s holds valid, mode, carry, completed sum lanes 0..s, and unconsumed operand lanes s+1..LANES-1.
- Stage s computes {c_s, sum_s} = a_lane_s + b_lane_s + cin (LANE_W+1-bit result).
  - cin = 0 for s=0.
  - For s>0: cin = c_(s-1) when the beat's mode=1, otherwise 0.
- Mode is captured with the beat and travels with it. Beats of different modes may be freely interleaved.
- Latency: a beat accepted at edge N appears on out_valid/out_sum/out_carry after edge N+LANES-1, i.e. the final stage registers drive the outputs directly. LANES=1 gives a one-cycle registered adder.
- Throughput: one beat per cycle when out_ready=1.
- Handshake:
  - advance = !out_valid || out_ready; the whole pipeline shifts by one stage only when advance=1.
  - in_ready = advance (combinational from out_ready and out_valid; no combinational in_valid->in_ready path).
  - A beat is accepted when in_valid && in_ready. If in_valid=0 while advancing, a bubble (valid=0) enters stage 0.
  - out_valid, out_sum and out_carry are held stable while out_valid && !out_ready. No beat is lost or duplicated.
  - Bubbles do not collapse during a stall; this is the decided behaviour.
- Arithmetic:
  - Unsigned modulo 2^LANE_W per lane in mode 0 and modulo 2^WIDTH in mode 1.
  - out_carry bits are reported in both modes.
  - No saturation and no subtraction.
- Simultaneous output consume and input accept in the same cycle is legal and sustains full rate.

Test Plan (WIDTH=32, LANE_W=8, latency 4):
- Packed: mode=0, a=0x80FF01FF, b=0x80010001 -> out_sum=0x00000100, out_carry=4'b1101, valid exactly 4 cycles after accept.
- Chained: mode=1, same operands -> out_sum=0x01000200, out_carry=4'b1101 (bit 3 = full carry-out).
- Wrap: a=0xFFFFFFFF, b=0x00000001.
  - mode=1 -> sum=0x00000000, carry=4'b1111.
  - mode=0 -> sum=0xFFFFFF00, carry=4'b0001.
- Streaming: 8 back-to-back beats with alternating modes, out_ready=1 -> results in order on 8 consecutive cycles starting 4 cycles after the first accept. Each result matches the per-mode reference model.
- Backpressure: full pipeline, out_ready=0 for 3 cycles -> in_ready=0, outputs stable all 3 cycles. After release, all beats delivered in order with none lost or duplicated.
- Reset mid-flight: 2 beats in flight, pulse rst_n low asynchronously (between edges) -> out_valid drops at once. After release, no results emerge until new beats are accepted, and in_ready=1.

Source files
------------

// File: rtl/pipelined_lane_adder.sv
// rtl/pipelined_lane_adder.sv - valid/ready pipelined adder, one lane per stage
// Mode 0 adds lanes independently; mode 1 ripples each lane carry into the next stage.
module pipelined_lane_adder #(
   parameter int WIDTH  = 32,
   parameter int LANE_W = 8,
   localparam int LANES = WIDTH / LANE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_sum,
   output logic [LANES-1:0]   out_carry
);

   generate
      if (WIDTH % LANE_W != 0) begin : g_bad_width
         $error("pipelined_lane_adder: WIDTH must be a multiple of LANE_W");
      end
   endgenerate

   logic               valid_q   [LANES];
   logic               mode_q    [LANES];
   logic [WIDTH-1:0]   a_q       [LANES];
   logic [WIDTH-1:0]   b_q       [LANES];
   logic [WIDTH-1:0]   sum_q     [LANES];
   logic [LANES-1:0]   carry_q   [LANES];

   logic               nxt_valid [LANES];
   logic               nxt_mode  [LANES];
   logic [WIDTH-1:0]   nxt_a     [LANES];
   logic [WIDTH-1:0]   nxt_b     [LANES];
   logic [WIDTH-1:0]   nxt_sum   [LANES];
   logic [LANES-1:0]   nxt_carry [LANES];
   logic [LANE_W:0]    lane_res  [LANES];
   logic               cin       [LANES];

   logic advance;

   assign advance   = !valid_q[LANES-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = valid_q[LANES-1];
   assign out_sum   = sum_q[LANES-1];
   assign out_carry = carry_q[LANES-1];

   // Stage s takes its inputs from stage s-1 (or the input port) and fills in lane s.
   always_comb begin
      int p;
      p = 0;
      for (int s = 0; s < LANES; s++) begin
         p = (s > 0) ? s - 1 : 0;
         if (s == 0) begin
            nxt_valid[s] = in_valid;
            nxt_mode[s]  = in_mode;
            nxt_a[s]     = in_a;
            nxt_b[s]     = in_b;
            nxt_sum[s]   = '0;
            nxt_carry[s] = '0;
            cin[s]       = 1'b0;
         end else begin
            nxt_valid[s] = valid_q[p];
            nxt_mode[s]  = mode_q[p];
            nxt_a[s]     = a_q[p];
            nxt_b[s]     = b_q[p];
            nxt_sum[s]   = sum_q[p];
            nxt_carry[s] = carry_q[p];
            cin[s]       = mode_q[p] & carry_q[p][p];
         end
         lane_res[s] = {1'b0, nxt_a[s][s*LANE_W +: LANE_W]}
                     + {1'b0, nxt_b[s][s*LANE_W +: LANE_W]}
                     + {{LANE_W{1'b0}}, cin[s]};
         nxt_sum[s][s*LANE_W +: LANE_W] = lane_res[s][LANE_W-1:0];
         nxt_carry[s][s]                = lane_res[s][LANE_W];
      end
   end

   // The whole pipeline moves as one; bubbles are kept during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < LANES; s++) begin
            valid_q[s] <= 1'b0;
            mode_q[s]  <= 1'b0;
            a_q[s]     <= '0;
            b_q[s]     <= '0;
            sum_q[s]   <= '0;
            carry_q[s] <= '0;
         end
      end else if (advance) begin
         for (int s = 0; s < LANES; s++) begin
            valid_q[s] <= nxt_valid[s];
            mode_q[s]  <= nxt_mode[s];
            a_q[s]     <= nxt_a[s];
            b_q[s]     <= nxt_b[s];
            sum_q[s]   <= nxt_sum[s];
            carry_q[s] <= nxt_carry[s];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_lane_adder.sv
// tb/tb_pipelined_lane_adder.sv - self-checking bench for pipelined_lane_adder
module tb_pipelined_lane_adder;

   localparam int WIDTH  = 32;
   localparam int LANE_W = 8;
   localparam int LANES  = WIDTH / LANE_W;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_sum;
   logic [LANES-1:0]   out_carry;

   always #5 clk = ~clk;

   pipelined_lane_adder #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry)
   );

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic [LANES-1:0] carry;
      int               acc;
   } exp_t;

   exp_t             exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               n_in     = 0;
   int               n_out    = 0;
   bit               use_model = 1'b0;
   bit               chk_lat   = 1'b0;
   bit               prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_sum;
   logic [LANES-1:0] prev_carry;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned lane_of(input longint unsigned v, input int i);
      return (v >> (i * LANE_W)) & ((64'd1 << LANE_W) - 1);
   endfunction

   function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic m);
      longint unsigned r;
      r = 0;
      if (m) r = (longint'(a) + longint'(b)) & ((64'd1 << WIDTH) - 1);
      else
         for (int i = 0; i < LANES; i++)
            r |= ((lane_of(a, i) + lane_of(b, i)) & ((64'd1 << LANE_W) - 1)) << (i * LANE_W);
      return r[WIDTH-1:0];
   endfunction

   function automatic logic [LANES-1:0] ref_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic m);
      logic [LANES-1:0] c;
      longint unsigned  mask;
      int               hi;
      c = '0;
      for (int i = 0; i < LANES; i++) begin
         hi = (i + 1) * LANE_W;
         mask = (64'd1 << hi) - 1;
         if (m) c[i] = (((longint'(a) & mask) + (longint'(b) & mask)) >> hi) != 0;
         else   c[i] = ((lane_of(a, i) + lane_of(b, i)) >> LANE_W) != 0;
      end
      return c;
   endfunction

   task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic m, input logic r);
      exp_t e;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_mode = m; out_ready = r;
      #1;
      cyc++;
      if (prev_stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_sum", out_sum, prev_sum);
         check("hold_carry", out_carry, prev_carry);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_carry = out_carry;
      if (use_model) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
            else begin
               e = exp_q.pop_front();
               check("sum", out_sum, e.sum);
               check("carry", out_carry, e.carry);
               if (chk_lat) check("latency", cyc - e.acc, LANES);
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            e.sum = ref_sum(a, b, m);
            e.carry = ref_carry(a, b, m);
            e.acc = cyc;
            exp_q.push_back(e);
            n_in++;
         end
      end
   endtask

   task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic m, input logic [WIDTH-1:0] es, input logic [LANES-1:0] ec);
      int n;
      cycle(1'b1, a, b, m, 1'b1);
      check({tag, "_accept"}, in_ready, 1);
      n = 0;
      do begin
         cycle(1'b0, '0, '0, 1'b0, 1'b1);
         n++;
      end while (!out_valid && n < 20);
      check({tag, "_latency"}, n, LANES);
      check({tag, "_sum"}, out_sum, es);
      check({tag, "_carry"}, out_carry, ec);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_carry", out_carry, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      check("rst_in_ready", in_ready, 1);
      check("rst_idle_valid", out_valid, 0);

      directed("packed",  32'h80FF01FF, 32'h80010001, 1'b0, 32'h00000100, 4'b1101);
      directed("chained", 32'h80FF01FF, 32'h80010001, 1'b1, 32'h01000200, 4'b1101);
      directed("wrap1",   32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b1111);
      directed("wrap0",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFF00, 4'b0001);

      // back-to-back alternating modes at full rate
      use_model = 1'b1;
      chk_lat = 1'b1;
      n_in = 0; n_out = 0;
      for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, $urandom, (i % 2) == 1, 1'b1);
      repeat (LANES + 2) cycle(1'b0, '0, '0, 1'b0, 1'b1);
      chk_lat = 1'b0;
      check("stream_in", n_in, 8);
      check("stream_out", n_out, 8);

      // fill, stall three cycles, then release
      for (int i = 0; i < LANES; i++) cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
      end
      for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      repeat (LANES + 4) cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("bp_in_eq_out", n_out, n_in);

      // random traffic with random backpressure
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 7));
      repeat (LANES + 6) cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("rand_in_eq_out", n_out, n_in);
      check("rand_queue_empty", exp_q.size(), 0);

      // reset while two beats are in flight
      cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b0);
      check("pre_rst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_sum", out_sum, 0);
      exp_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, '0, '0, 1'b0, 1'b1);
         check("post_rst_valid", out_valid, 0);
         check("post_rst_in_ready", in_ready, 1);
      end
      n_in = 0; n_out = 0;
      cycle(1'b1, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b1);
      repeat (LANES + 2) cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("post_rst_beat", n_out, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
